// File: rtl/ofmap_accum_buffer.sv
// ofmap_accum_buffer
//   Collects the top-row psums of a PE array. There is one lane per PE column.
//   Each lane accumulates into a per-row buffer entry over num_passes passes.
//   The finished rows are then streamed out, saturated to the output width,
//   under a valid/ready handshake.
//
// Ports
//   clk, rstb          clock, synchronous active-high reset
//   start              one-cycle job request, only honoured in IDLE
//   num_rows           rows per pass (1..ROW_DEPTH), latched on start
//   num_passes         passes to accumulate, latched on start (0 means 1)
//   busy               high while accumulating or draining
//   psum_valid/ready   psum row handshake; psum_in packs lane k at [k*BITWIDTH +: BITWIDTH]
//   ofmap_valid/ready  output row handshake; ofmap uses the same lane packing
//   ofmap_last         marks the final drained row
//   done               one-cycle pulse after the final row is accepted
module ofmap_accum_buffer #(
  parameter int BITWIDTH   = 16,
  parameter int PE_X_SIZE  = 3,
  parameter int ROW_DEPTH  = 8,
  parameter int ROW_ADDR_W = 3,
  parameter int PASS_W     = 4,
  parameter int ACC_WIDTH  = 2*BITWIDTH
) (
  input  logic                            clk,
  input  logic                            rstb,
  input  logic                            start,
  input  logic [ROW_ADDR_W-1:0]           num_rows,
  input  logic [PASS_W-1:0]               num_passes,
  output logic                            busy,
  input  logic                            psum_valid,
  output logic                            psum_ready,
  input  logic [PE_X_SIZE*BITWIDTH-1:0]   psum_in,
  output logic                            ofmap_valid,
  input  logic                            ofmap_ready,
  output logic [PE_X_SIZE*BITWIDTH-1:0]   ofmap,
  output logic                            ofmap_last,
  output logic                            done
);

  typedef enum logic [1:0] {IDLE, ACCUM, DRAIN} state_t;

  state_t                  state_q;
  logic [ROW_ADDR_W-1:0]   row_q;
  logic [PASS_W-1:0]       pass_q;
  logic [ROW_ADDR_W-1:0]   nrows_q;
  logic [PASS_W-1:0]       npass_q;
  logic                    done_q;

  logic signed [ACC_WIDTH-1:0] mem_q [ROW_DEPTH][PE_X_SIZE];
  logic signed [BITWIDTH-1:0]  lane_in [PE_X_SIZE];

  logic start_ok;
  logic row_last;
  logic pass_last;
  logic beat_acc;
  logic row_acc;

  function automatic logic signed [ACC_WIDTH-1:0] sext(input logic signed [BITWIDTH-1:0] v);
    return {{(ACC_WIDTH-BITWIDTH){v[BITWIDTH-1]}}, v};
  endfunction

  // Add one extra bit of headroom. If the top two bits of the sum differ,
  // the accumulator overflowed, and the top bit gives the direction to clamp.
  function automatic logic signed [ACC_WIDTH-1:0] sat_acc(
    input logic signed [ACC_WIDTH-1:0] a,
    input logic signed [BITWIDTH-1:0]  b
  );
    logic signed [ACC_WIDTH-1:0] be;
    logic signed [ACC_WIDTH:0]   s;
    be = sext(b);
    s  = {a[ACC_WIDTH-1], a} + {be[ACC_WIDTH-1], be};
    if (s[ACC_WIDTH] != s[ACC_WIDTH-1])
      return s[ACC_WIDTH] ? {1'b1, {(ACC_WIDTH-1){1'b0}}} : {1'b0, {(ACC_WIDTH-1){1'b1}}};
    return s[ACC_WIDTH-1:0];
  endfunction

  // The value fits in BITWIDTH when all bits from the output sign bit upward agree.
  function automatic logic signed [BITWIDTH-1:0] sat_out(input logic signed [ACC_WIDTH-1:0] a);
    if ((&a[ACC_WIDTH-1:BITWIDTH-1]) || ~(|a[ACC_WIDTH-1:BITWIDTH-1]))
      return a[BITWIDTH-1:0];
    return a[ACC_WIDTH-1] ? {1'b1, {(BITWIDTH-1){1'b0}}} : {1'b0, {(BITWIDTH-1){1'b1}}};
  endfunction

  always_comb begin
    for (int k = 0; k < PE_X_SIZE; k++)
      lane_in[k] = psum_in[k*BITWIDTH +: BITWIDTH];
  end

  assign start_ok  = (num_rows != '0) && (int'(num_rows) <= ROW_DEPTH);
  assign row_last  = (row_q == nrows_q - ROW_ADDR_W'(1));
  assign pass_last = (pass_q == npass_q - PASS_W'(1));
  assign beat_acc  = (state_q == ACCUM) && psum_valid;
  assign row_acc   = (state_q == DRAIN) && ofmap_ready;

  // Control: sequencing FSM, row/pass pointers and the done pulse
  always_ff @(posedge clk) begin
    if (rstb) begin
      state_q <= IDLE;
      row_q   <= '0;
      pass_q  <= '0;
      nrows_q <= '0;
      npass_q <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start && start_ok) begin
            nrows_q <= num_rows;
            npass_q <= (num_passes == '0) ? PASS_W'(1) : num_passes;
            row_q   <= '0;
            pass_q  <= '0;
            state_q <= ACCUM;
          end
        end
        ACCUM: begin
          if (beat_acc) begin
            if (row_last) begin
              row_q <= '0;
              if (pass_last) begin
                pass_q  <= '0;
                state_q <= DRAIN;
              end else begin
                pass_q <= pass_q + PASS_W'(1);
              end
            end else begin
              row_q <= row_q + ROW_ADDR_W'(1);
            end
          end
        end
        DRAIN: begin
          if (row_acc) begin
            if (row_last) begin
              row_q   <= '0;
              done_q  <= 1'b1;
              state_q <= IDLE;
            end else begin
              row_q <= row_q + ROW_ADDR_W'(1);
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Accumulation buffer: pass 0 overwrites, later passes saturating-add
  always_ff @(posedge clk) begin
    if (beat_acc) begin
      for (int k = 0; k < PE_X_SIZE; k++)
        mem_q[row_q][k] <= (pass_q == '0) ? sext(lane_in[k]) : sat_acc(mem_q[row_q][k], lane_in[k]);
    end
  end

  // Drain output: combinational read of the current row, zero outside DRAIN
  always_comb begin
    ofmap = '0;
    if (state_q == DRAIN) begin
      for (int k = 0; k < PE_X_SIZE; k++)
        ofmap[k*BITWIDTH +: BITWIDTH] = sat_out(mem_q[row_q][k]);
    end
  end

  assign busy        = (state_q != IDLE);
  assign psum_ready  = (state_q == ACCUM);
  assign ofmap_valid = (state_q == DRAIN);
  assign ofmap_last  = (state_q == DRAIN) && row_last;
  assign done        = done_q;

endmodule

// File: tb/tb_ofmap_accum_buffer.sv
// Scoreboard bench for ofmap_accum_buffer. The driver pushes the expected rows
// of each job, computed directly from the psum values it will send. A negedge
// monitor pops one expected row per accepted output row and checks the done pulse.
module tb_ofmap_accum_buffer;
  localparam int BW  = 16;
  localparam int NX  = 3;
  localparam int RD  = 8;
  localparam int RAW = 3;
  localparam int PW  = 4;

  logic              clk = 1'b0;
  logic              rstb = 1'b1;
  logic              start = 1'b0;
  logic [RAW-1:0]    num_rows = '0;
  logic [PW-1:0]     num_passes = '0;
  logic              busy;
  logic              psum_valid = 1'b0;
  logic              psum_ready;
  logic [NX*BW-1:0]  psum_in = '0;
  logic              ofmap_valid;
  logic              ofmap_ready = 1'b0;
  logic [NX*BW-1:0]  ofmap;
  logic              ofmap_last;
  logic              done;

  ofmap_accum_buffer #(.BITWIDTH(BW), .PE_X_SIZE(NX), .ROW_DEPTH(RD),
                       .ROW_ADDR_W(RAW), .PASS_W(PW), .ACC_WIDTH(2*BW)) dut (
    .clk(clk), .rstb(rstb), .start(start), .num_rows(num_rows),
    .num_passes(num_passes), .busy(busy), .psum_valid(psum_valid),
    .psum_ready(psum_ready), .psum_in(psum_in), .ofmap_valid(ofmap_valid),
    .ofmap_ready(ofmap_ready), .ofmap(ofmap), .ofmap_last(ofmap_last), .done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [NX*BW-1:0] data;
    bit               last;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   beat_mem [16][RD][NX];
  int   n_chk = 0;
  int   n_fail = 0;
  bit   exp_done = 1'b0;
  int   rdy_mode = 0;   // 0 random, 1 always ready, 2 never ready

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic longint clampv(input longint v, input int w);
    longint lo, hi;
    lo = -(longint'(1) << (w-1));
    hi = (longint'(1) << (w-1)) - 1;
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  function automatic logic [NX*BW-1:0] pack(input int p, input int r);
    logic [NX*BW-1:0] res;
    for (int k = 0; k < NX; k++) res[k*BW +: BW] = BW'(beat_mem[p][r][k]);
    return res;
  endfunction

  // Reference: a plain running sum per entry, clamped to the accumulator
  // range after every pass and then to the output range.
  task automatic push_expected(input int nr, input int np);
    exp_t   e;
    longint acc;
    for (int r = 0; r < nr; r++) begin
      for (int k = 0; k < NX; k++) begin
        acc = beat_mem[0][r][k];
        for (int p = 1; p < np; p++) acc = clampv(acc + beat_mem[p][r][k], 2*BW);
        acc = clampv(acc, BW);
        e.data[k*BW +: BW] = acc[BW-1:0];
      end
      e.last = (r == nr-1);
      exp_q.push_back(e);
    end
  endtask

  // Output ready generator
  always begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       ofmap_ready = ($urandom % 4) != 0;
      1:       ofmap_ready = 1'b1;
      default: ofmap_ready = 1'b0;
    endcase
  end

  // Monitor: a handshake seen here is taken on the next rising edge
  always @(negedge clk) begin
    if (exp_done || done) chk("done_pulse", longint'(done), longint'(exp_done));
    exp_done = 1'b0;
    if (!rstb && ofmap_valid && ofmap_ready) begin
      chk("row_expected", longint'(exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        mon_e = exp_q.pop_front();
        chk("ofmap_row", longint'(ofmap), longint'(mon_e.data));
        chk("ofmap_last", longint'(ofmap_last), longint'(mon_e.last));
        exp_done = mon_e.last;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic do_start(input int nr, input int npf);
    tick();
    start = 1'b1; num_rows = RAW'(nr); num_passes = PW'(npf);
    tick();
    start = 1'b0;
  endtask

  task automatic feed(input int nr, input int np, input int nbeats);
    int cnt;
    int g;
    bit acc;
    bit v;
    logic [63:0] rnd;
    cnt = 0;
    for (int p = 0; p < np; p++)
      for (int r = 0; r < nr; r++)
        if (cnt < nbeats) begin
          acc = 1'b0; g = 0;
          while (!acc && g < 100) begin
            v = ($urandom % 4) != 0;
            rnd = {$urandom, $urandom};
            psum_valid = v;
            psum_in = v ? pack(p, r) : rnd[NX*BW-1:0];
            acc = v && psum_ready;
            tick();
            g++;
          end
          if (!acc) chk("beat_accept_timeout", longint'(acc), 1);
          cnt++;
        end
    psum_valid = 1'b0;
  endtask

  task automatic wait_idle(output int cycles);
    cycles = 0;
    while (busy && cycles < 500) begin
      tick();
      cycles++;
    end
    chk("job_completes", longint'(busy), 0);
  endtask

  task automatic run_job(input int nr, input int npf, input int mode);
    int np;
    int cyc;
    logic [NX*BW-1:0] snap;
    np = (npf == 0) ? 1 : npf;
    rdy_mode = mode;
    push_expected(nr, np);
    do_start(nr, npf);
    chk("busy_after_start", longint'(busy), 1);
    feed(nr, np, nr*np);
    chk("psum_ready_in_drain", longint'(psum_ready), 0);
    chk("ofmap_valid_latency", longint'(ofmap_valid), 1);
    if (mode == 2) begin
      snap = ofmap;
      for (int i = 0; i < 5; i++) begin
        start = (i == 1); num_rows = RAW'(1); num_passes = PW'(1);
        tick();
        chk("bp_ofmap_stable", longint'(ofmap), longint'(snap));
        chk("bp_valid_held", longint'(ofmap_valid), 1);
        chk("bp_busy_held", longint'(busy), 1);
      end
      start = 1'b0;
      rdy_mode = 0;
    end
    wait_idle(cyc);
    if (mode == 1) chk("drain_cycles", cyc, nr);
    tick();
  endtask

  function automatic int rnd_val();
    case ($urandom % 8)
      0:       return 32767;
      1:       return -32768;
      default: return int'($urandom_range(0, 65535)) - 32768;
    endcase
  endfunction

  initial begin
    int nr, npf;
    // Reset and idle behaviour
    psum_valid = 1'b1;
    tick(); tick();
    chk("rst_busy", longint'(busy), 0);
    chk("rst_psum_ready", longint'(psum_ready), 0);
    chk("rst_ofmap_valid", longint'(ofmap_valid), 0);
    chk("rst_ofmap_last", longint'(ofmap_last), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_ofmap", longint'(ofmap), 0);
    rstb = 1'b0;
    tick(); tick();
    chk("idle_ignores_psum", longint'(psum_ready), 0);
    chk("idle_busy", longint'(busy), 0);
    psum_valid = 1'b0;

    // Out-of-range start is ignored
    do_start(0, 1);
    chk("start_rows0_ignored", longint'(busy), 0);

    // Single pass, two rows
    beat_mem[0][0] = '{1, 2, 3};
    beat_mem[0][1] = '{4, 5, 6};
    run_job(2, 1, 0);

    // Three passes on one row, then num_passes 0 vs 1
    beat_mem[0][0] = '{10, -5, 0};
    beat_mem[1][0] = '{20, -5, 7};
    beat_mem[2][0] = '{1, -5, -7};
    run_job(1, 3, 0);
    run_job(1, 0, 0);
    run_job(1, 1, 0);

    // Output saturation in both directions
    for (int p = 0; p < 4; p++) beat_mem[p][0] = '{32767, 100, -100};
    run_job(1, 4, 0);
    for (int p = 0; p < 4; p++) beat_mem[p][0] = '{-32768, 32767, -32768};
    run_job(1, 4, 0);

    // Back-pressure with an ignored start, and fixed-length drain
    for (int r = 0; r < 3; r++) beat_mem[0][r] = '{r+11, r+21, r+31};
    run_job(3, 1, 2);
    run_job(3, 1, 1);

    // Reset in the middle of a job
    rdy_mode = 0;
    for (int r = 0; r < 4; r++) beat_mem[0][r] = '{99, 98, 97};
    do_start(4, 1);
    feed(4, 1, 1);
    rstb = 1'b1;
    tick();
    rstb = 1'b0;
    chk("midrst_busy", longint'(busy), 0);
    chk("midrst_psum_ready", longint'(psum_ready), 0);
    chk("midrst_ofmap_valid", longint'(ofmap_valid), 0);
    repeat (3) tick();
    beat_mem[0][0] = '{7, 7, 7};
    run_job(1, 1, 0);

    // Randomized jobs
    for (int j = 0; j < 12; j++) begin
      nr  = $urandom_range(1, 7);
      npf = $urandom_range(0, 5);
      for (int p = 0; p < 6; p++)
        for (int r = 0; r < RD; r++)
          for (int k = 0; k < NX; k++) beat_mem[p][r][k] = rnd_val();
      run_job(nr, npf, $urandom_range(0, 1));
    end

    repeat (5) tick();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
